// File: rtl/grn_pkg.sv
// ---------------------------------------------------------------------------
// grn_pkg
// Shared definitions for the GRN attractor search controller: the controller
// FSM state type, default counter width and step limit, and a small helper
// that says whether a state is allowed to accept a new search request.
// ---------------------------------------------------------------------------
package grn_pkg;

   // Controller phases: idle, one-cycle node load, Floyd tortoise/hare run,
   // period measurement around the attractor, and results-valid.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_RUN    = 3'd2,
      ST_PERIOD = 3'd3,
      ST_DONE   = 3'd4
   } grn_state_t;

   // Default width of the step and period counters.
   localparam int GRN_CNT_W = 16;

   // Default per-phase step budget before a search is abandoned.
   localparam int GRN_MAX_STEPS = 1000;

   // A new search may only be launched from a quiescent state; a request
   // arriving while the node array is being driven is dropped.
   function automatic logic accepts_start(input grn_state_t s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/grn_step_counter.sv
// ---------------------------------------------------------------------------
// grn_step_counter
// Clearable, incrementing, saturating counter used to track visible node
// steps during one search phase. at_max flags the step budget so the
// controller can abandon the phase.
//
// Ports
//   clk     in   1       clock
//   rst     in   1       synchronous reset, active-high
//   clr     in   1       return the count to zero
//   inc     in   1       advance by one (ignored once saturated)
//   count   out  CNT_W   current count
//   at_max  out  1       count equals MAX_STEPS
// ---------------------------------------------------------------------------
module grn_step_counter
   import grn_pkg::*;
#(
   parameter int CNT_W     = GRN_CNT_W,
   parameter int MAX_STEPS = GRN_MAX_STEPS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_STEPS);
   localparam logic [CNT_W-1:0] SAT_VAL = '1;

   // The count sticks at all-ones instead of wrapping, so a runaway phase can
   // never alias back onto a small step number and fake a short attractor.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != SAT_VAL)) begin
         count <= count + CNT_W'(1);
      end
   end

   // Budget flag is decoded straight from the count so the controller sees it
   // in the same cycle the last allowed step becomes visible.
   assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// grn_attractor_ctrl
// Drives an array of two-trajectory GRN nodes to find the attractor reached
// from a given initial state. Nodes are loaded, then stepped with the
// tortoise (s0, advances every second step) and hare (s1, advances every
// step) until they agree (Floyd cycle detection). The meeting state is
// captured and the hare alone is stepped until it returns to it, which gives
// the attractor period.
//
// Ports
//   clk         in   1        clock
//   rst         in   1        synchronous reset, active-high
//   start       in   1        begin a search (honoured in IDLE/DONE only)
//   init_vec    in   N_NODES  initial network state, latched on start
//   s0_vec      in   N_NODES  node tortoise outputs
//   s1_vec      in   N_NODES  node hare outputs
//   reset_nos   out  1        node load strobe, high for the LOAD cycle
//   init_state  out  N_NODES  per-node load value (bit i -> node i)
//   start_s0    out  1        tortoise step enable
//   start_s1    out  1        hare step enable
//   busy        out  1        search in progress
//   done        out  1        results valid and stable
//   timeout     out  1        search abandoned at the step budget
//   meet_steps  out  CNT_W    hare steps taken when tortoise and hare met
//   period      out  CNT_W    attractor length
//   attractor   out  N_NODES  tortoise state captured at the meet
// ---------------------------------------------------------------------------
module grn_attractor_ctrl
   import grn_pkg::*;
#(
   parameter int N_NODES   = 3,
   parameter int CNT_W     = GRN_CNT_W,
   parameter int MAX_STEPS = GRN_MAX_STEPS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_NODES-1:0] init_vec,
   input  logic [N_NODES-1:0] s0_vec,
   input  logic [N_NODES-1:0] s1_vec,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   output logic               busy,
   output logic               done,
   output logic               timeout,
   output logic [CNT_W-1:0]   meet_steps,
   output logic [CNT_W-1:0]   period,
   output logic [N_NODES-1:0] attractor
);

   grn_state_t       state;
   logic [CNT_W-1:0] k_cnt;
   logic [CNT_W-1:0] p_cnt;
   logic             k_max;
   logic             p_max;
   logic             start_ok;
   logic             match_run;
   logic             match_per;
   logic             run_step;
   logic             per_step;

   // A request is only taken when the controller is quiescent.
   assign start_ok = start && accepts_start(state);

   // The tortoise sits at ceil(k/2), so for odd k (or k==0) it can share an
   // index with the hare and compare equal without any cycle existing. Only
   // even k from 2 upward is a genuine Floyd meeting.
   assign match_run = (state == ST_RUN) && !k_cnt[0] &&
                      (k_cnt >= CNT_W'(2)) && (s0_vec == s1_vec);

   // At p==0 the hare is still sitting on the captured state, which would
   // otherwise read as a period of zero.
   assign match_per = (state == ST_PERIOD) && (p_cnt != '0) &&
                      (s1_vec == attractor);

   // Steps are withheld in the cycle that resolves a phase, either by a
   // match or by hitting the budget, so the nodes freeze on the result.
   assign run_step = (state == ST_RUN)    && !match_run && !k_max;
   assign per_step = (state == ST_PERIOD) && !match_per && !p_max;

   // Both trajectories move together while searching; only the hare moves
   // while walking once around the attractor.
   assign start_s0 = run_step;
   assign start_s1 = run_step || per_step;

   // k counts hare steps issued during the run phase. A step issued this
   // cycle is reflected in the node outputs and in k on the next cycle.
   grn_step_counter #(
      .CNT_W     (CNT_W),
      .MAX_STEPS (MAX_STEPS)
   ) u_k_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .inc    (run_step),
      .count  (k_cnt),
      .at_max (k_max)
   );

   // p counts hare steps taken after the meet while looking for the return.
   grn_step_counter #(
      .CNT_W     (CNT_W),
      .MAX_STEPS (MAX_STEPS)
   ) u_p_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (start_ok),
      .inc    (per_step),
      .count  (p_cnt),
      .at_max (p_max)
   );

   // Search sequencer. All outputs except the step enables are registered
   // here. A match is checked before the budget so that a meeting found on
   // the very last permitted step is still reported as a success. Results
   // (meet_steps, period, attractor) are only overwritten on a capture, so a
   // timed-out search leaves the previous capture visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         reset_nos  <= 1'b0;
         init_state <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         meet_steps <= '0;
         period     <= '0;
         attractor  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  state      <= ST_LOAD;
                  init_state <= init_vec;
                  reset_nos  <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  timeout    <= 1'b0;
               end
            end
            ST_LOAD: begin
               state     <= ST_RUN;
               reset_nos <= 1'b0;
            end
            ST_RUN: begin
               if (match_run) begin
                  state      <= ST_PERIOD;
                  attractor  <= s0_vec;
                  meet_steps <= k_cnt;
               end else if (k_max) begin
                  state   <= ST_DONE;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            ST_PERIOD: begin
               if (match_per) begin
                  state  <= ST_DONE;
                  period <= p_cnt;
                  busy   <= 1'b0;
                  done   <= 1'b1;
               end else if (p_max) begin
                  state   <= ST_DONE;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               reset_nos <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_grn_attractor_ctrl
// Two controller instances sit on behavioural node arrays: instance A with
// the default step budget and instance B with a budget of 4 so that both
// timeout paths can be reached. Each node array applies a selectable update
// function f (identity, rotate-left, constant, +1, or a random lookup table)
// with the tortoise pass semantics. Expected results come from a direct
// iteration of f in plain arithmetic.
// ---------------------------------------------------------------------------
module tb_grn_attractor_ctrl;

   localparam int N          = 3;
   localparam int CW         = 16;
   localparam int MAX_A      = 1000;
   localparam int MAX_B      = 4;
   localparam int WAIT_LIMIT = 5000;

   localparam int F_IDENT = 0;
   localparam int F_ROTL  = 1;
   localparam int F_CONST = 2;
   localparam int F_INC   = 3;
   localparam int F_TABLE = 4;

   logic clk = 1'b0;

   logic          rst_a   = 1'b1;
   logic          start_a = 1'b0;
   logic [N-1:0]  init_a  = '0;
   logic [N-1:0]  s0_a    = '0;
   logic [N-1:0]  s1_a    = '0;
   logic          pass_a  = 1'b0;
   logic          reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a;
   logic [N-1:0]  init_state_a, attr_a;
   logic [CW-1:0] meet_a, period_a;

   logic          rst_b   = 1'b1;
   logic          start_b = 1'b0;
   logic [N-1:0]  init_b  = '0;
   logic [N-1:0]  s0_b    = '0;
   logic [N-1:0]  s1_b    = '0;
   logic          pass_b  = 1'b0;
   logic          reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b;
   logic [N-1:0]  init_state_b, attr_b;
   logic [CW-1:0] meet_b, period_b;

   int            mode_a = 0;
   int            mode_b = 0;
   logic [23:0]   tbl_a  = '0;
   logic [23:0]   tbl_b  = '0;

   int            tests = 0;
   int            fails = 0;

   int            prev_meet_b = 0;
   int            prev_per_b  = 0;
   logic [N-1:0]  prev_attr_b = '0;

   // Free-running clock shared by both instances.
   always #5 clk = ~clk;

   grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAX_A)) dut_a (
      .clk        (clk),
      .rst        (rst_a),
      .start      (start_a),
      .init_vec   (init_a),
      .s0_vec     (s0_a),
      .s1_vec     (s1_a),
      .reset_nos  (reset_nos_a),
      .init_state (init_state_a),
      .start_s0   (start_s0_a),
      .start_s1   (start_s1_a),
      .busy       (busy_a),
      .done       (done_a),
      .timeout    (timeout_a),
      .meet_steps (meet_a),
      .period     (period_a),
      .attractor  (attr_a)
   );

   grn_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(MAX_B)) dut_b (
      .clk        (clk),
      .rst        (rst_b),
      .start      (start_b),
      .init_vec   (init_b),
      .s0_vec     (s0_b),
      .s1_vec     (s1_b),
      .reset_nos  (reset_nos_b),
      .init_state (init_state_b),
      .start_s0   (start_s0_b),
      .start_s1   (start_s1_b),
      .busy       (busy_b),
      .done       (done_b),
      .timeout    (timeout_b),
      .meet_steps (meet_b),
      .period     (period_b),
      .attractor  (attr_b)
   );

   // Network update function applied by every node array.
   function automatic logic [N-1:0] fnode(input int mode, input logic [23:0] tbl,
                                          input logic [N-1:0] x);
      case (mode)
         F_IDENT: return x;
         F_ROTL:  return {x[1:0], x[2]};
         F_CONST: return 3'b110;
         F_INC:   return x + 3'd1;
         default: return tbl[int'(x)*3 +: 3];
      endcase
   endfunction

   // Node array A: load on reset_nos; the hare applies f on every step, the
   // tortoise on the first step after a load and every second one after.
   always @(posedge clk) begin
      if (reset_nos_a) begin
         s0_a   <= init_state_a;
         s1_a   <= init_state_a;
         pass_a <= 1'b1;
      end else begin
         if (start_s0_a) begin
            if (pass_a) s0_a <= fnode(mode_a, tbl_a, s0_a);
            pass_a <= ~pass_a;
         end
         if (start_s1_a) s1_a <= fnode(mode_a, tbl_a, s1_a);
      end
   end

   // Node array B, same behaviour as array A.
   always @(posedge clk) begin
      if (reset_nos_b) begin
         s0_b   <= init_state_b;
         s1_b   <= init_state_b;
         pass_b <= 1'b1;
      end else begin
         if (start_s0_b) begin
            if (pass_b) s0_b <= fnode(mode_b, tbl_b, s0_b);
            pass_b <= ~pass_b;
         end
         if (start_s1_b) s1_b <= fnode(mode_b, tbl_b, s1_b);
      end
   end

   // Reference: iterate f directly. The hare is f^k(x0) and the tortoise
   // f^ceil(k/2)(x0); the first even k>=2 where they agree is the meet. The
   // period is the first p>=1 with f^p(meet state) == meet state. Busy time
   // is one load cycle plus one cycle per observed k and p value.
   task automatic model(input int mode, input logic [23:0] tbl, input logic [N-1:0] x0,
                        input int maxs, input int pm_in, input int pp_in,
                        input logic [N-1:0] pa_in,
                        output int e_meet, output int e_per, output logic [N-1:0] e_attr,
                        output logic e_to, output int e_busy, output int e_steps);
      logic [N-1:0] h, t, y;
      int km, pmv;
      bit found;
      e_meet = pm_in; e_per = pp_in; e_attr = pa_in; e_to = 1'b0;
      h = x0; t = x0; found = 0; km = 0; pmv = 0;
      for (int k = 1; k <= maxs; k++) begin
         h = fnode(mode, tbl, h);
         if (k % 2 == 1) t = fnode(mode, tbl, t);
         if ((k % 2 == 0) && (h == t)) begin found = 1; km = k; break; end
      end
      if (!found) begin
         e_to = 1'b1; e_busy = maxs + 2; e_steps = maxs;
         return;
      end
      e_meet = km; e_attr = t;
      y = t; found = 0;
      for (int p = 1; p <= maxs; p++) begin
         y = fnode(mode, tbl, y);
         if (y == t) begin found = 1; pmv = p; break; end
      end
      if (!found) begin
         e_to = 1'b1; e_busy = 1 + (km + 1) + (maxs + 1); e_steps = km + maxs;
         return;
      end
      e_per = pmv; e_busy = 1 + (km + 1) + (pmv + 1); e_steps = km + pmv;
   endtask

   // Launches a search on one instance and follows it to done, counting busy,
   // load-strobe and hare-step cycles. poke_at >= 1 re-pulses start with a
   // different init value that many cycles in, which must be ignored.
   task automatic run_search(input int inst, input int poke_at,
                             output int busy_cyc, output int rnos_cyc, output int s1_cyc,
                             output logic to_first, output bit fin);
      logic bz, rn, st, dn, tf;
      busy_cyc = 0; rnos_cyc = 0; s1_cyc = 0; to_first = 1'bx; fin = 1'b0;
      @(negedge clk);
      if (inst == 0) start_a = 1'b1; else start_b = 1'b1;
      for (int c = 0; c < WAIT_LIMIT; c++) begin
         @(negedge clk);
         if (c == 0 || c == poke_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
         if (c == poke_at) begin
            if (inst == 0) begin start_a = 1'b1; init_a = ~init_a; end
            else begin start_b = 1'b1; init_b = ~init_b; end
         end
         if (inst == 0) begin
            bz = busy_a; rn = reset_nos_a; st = start_s1_a; dn = done_a; tf = timeout_a;
         end else begin
            bz = busy_b; rn = reset_nos_b; st = start_s1_b; dn = done_b; tf = timeout_b;
         end
         if (c == 0) to_first = tf;
         busy_cyc += int'(bz);
         rnos_cyc += int'(rn);
         s1_cyc   += int'(st);
         if (dn) begin fin = 1'b1; break; end
      end
      start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if ({reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a,
           init_state_a, attr_a, meet_a, period_a} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_a outputs busy=%b done=%b to=%b meet=%0d per=%0d attr=%b, all 0 required",
                  busy_a, done_a, timeout_a, meet_a, period_a, attr_a);
      end
      tests++;
      if ({reset_nos_b, start_s0_b, start_s1_b, busy_b, done_b, timeout_b,
           init_state_b, attr_b, meet_b, period_b} !== '0) begin
         fails++;
         $display("[TB] FAIL reset_b outputs busy=%b done=%b to=%b meet=%0d per=%0d attr=%b, all 0 required",
                  busy_b, done_b, timeout_b, meet_b, period_b, attr_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      prev_meet_b = 0; prev_per_b = 0; prev_attr_b = '0;
      repeat (2) @(negedge clk);
      tests++;
      if ({busy_a, done_a, reset_nos_a, busy_b, done_b, reset_nos_b} !== 6'b0) begin
         fails++;
         $display("[TB] FAIL idle_after_reset busy/done/rnos a=%b%b%b b=%b%b%b, 000 required",
                  busy_a, done_a, reset_nos_a, busy_b, done_b, reset_nos_b);
      end
   endtask

   task automatic test_identity();
      int bc, rc, sc, e_meet, e_per, e_busy, e_steps;
      logic [N-1:0] e_attr;
      logic tf, e_to;
      bit fin;
      mode_a = F_IDENT; init_a = 3'b101;
      model(F_IDENT, '0, 3'b101, MAX_A, 0, 0, '0, e_meet, e_per, e_attr, e_to, e_busy, e_steps);
      run_search(0, -1, bc, rc, sc, tf, fin);
      tests++;
      if (!fin) begin fails++; $display("[TB] FAIL identity_done not reached in %0d cycles", WAIT_LIMIT); end
      tests++;
      if (meet_a !== 16'd2 || period_a !== 16'd1) begin
         fails++;
         $display("[TB] FAIL identity_result meet=%0d period=%0d, required meet=2 period=1", meet_a, period_a);
      end
      tests++;
      if (attr_a !== 3'b101 || timeout_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL identity_attr attr=%b to=%b, required attr=101 to=0", attr_a, timeout_a);
      end
      tests++;
      if (bc !== e_busy || busy_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL identity_busy cycles=%0d busy_now=%b, required cycles=%0d busy_now=0", bc, busy_a, e_busy);
      end
   endtask

   task automatic test_rotl();
      int bc, rc, sc, e_meet, e_per, e_busy, e_steps;
      logic [N-1:0] e_attr;
      logic tf, e_to;
      bit fin;
      mode_a = F_ROTL; init_a = 3'b001;
      model(F_ROTL, '0, 3'b001, MAX_A, 0, 0, '0, e_meet, e_per, e_attr, e_to, e_busy, e_steps);
      run_search(0, -1, bc, rc, sc, tf, fin);
      tests++;
      if (!fin) begin fails++; $display("[TB] FAIL rotl_done not reached in %0d cycles", WAIT_LIMIT); end
      tests++;
      if (meet_a !== 16'd6 || period_a !== 16'd3 || attr_a !== 3'b001 || timeout_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL rotl_result meet=%0d period=%0d attr=%b to=%b, required 6 3 001 0",
                  meet_a, period_a, attr_a, timeout_a);
      end
      tests++;
      if (rc !== 1) begin
         fails++;
         $display("[TB] FAIL rotl_reset_nos high for %0d cycles, required 1", rc);
      end
      tests++;
      if (init_state_a !== 3'b001) begin
         fails++;
         $display("[TB] FAIL rotl_init_state got %b, required 001", init_state_a);
      end
      tests++;
      if (bc !== e_busy || sc !== e_steps) begin
         fails++;
         $display("[TB] FAIL rotl_timing busy=%0d steps=%0d, required busy=%0d steps=%0d", bc, sc, e_busy, e_steps);
      end
   endtask

   task automatic test_const();
      int bc, rc, sc;
      logic tf;
      bit fin;
      mode_a = F_CONST; init_a = 3'b011;
      run_search(0, -1, bc, rc, sc, tf, fin);
      tests++;
      if (!fin) begin fails++; $display("[TB] FAIL const_done not reached in %0d cycles", WAIT_LIMIT); end
      tests++;
      if (meet_a !== 16'd2 || period_a !== 16'd1 || attr_a !== 3'b110 || timeout_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL const_result meet=%0d period=%0d attr=%b to=%b, required 2 1 110 0",
                  meet_a, period_a, attr_a, timeout_a);
      end
   endtask

   task automatic test_timeout();
      int bc, rc, sc, e_meet, e_per, e_busy, e_steps;
      logic [N-1:0] e_attr, x0;
      logic tf, e_to;
      bit fin;
      x0 = 3'($urandom_range(0, 7));
      mode_b = F_INC; init_b = x0;
      model(F_INC, '0, x0, MAX_B, prev_meet_b, prev_per_b, prev_attr_b,
            e_meet, e_per, e_attr, e_to, e_busy, e_steps);
      run_search(1, -1, bc, rc, sc, tf, fin);
      tests++;
      if (!fin) begin fails++; $display("[TB] FAIL timeout_done not reached in %0d cycles", WAIT_LIMIT); end
      tests++;
      if (timeout_b !== 1'b1 || done_b !== 1'b1) begin
         fails++;
         $display("[TB] FAIL timeout_flag to=%b done=%b, required to=1 done=1", timeout_b, done_b);
      end
      tests++;
      if (meet_b !== 16'd0 || period_b !== 16'd0 || attr_b !== 3'b000) begin
         fails++;
         $display("[TB] FAIL timeout_results meet=%0d period=%0d attr=%b, required 0 0 000", meet_b, period_b, attr_b);
      end
      tests++;
      if (sc !== 4 || bc !== e_busy) begin
         fails++;
         $display("[TB] FAIL timeout_steps steps=%0d busy=%0d, required steps=4 busy=%0d", sc, bc, e_busy);
      end
      repeat (3) @(negedge clk);
      tests++;
      if (start_s0_b !== 1'b0 || start_s1_b !== 1'b0 || done_b !== 1'b1) begin
         fails++;
         $display("[TB] FAIL timeout_hold s0=%b s1=%b done=%b, required 0 0 1", start_s0_b, start_s1_b, done_b);
      end
      prev_meet_b = e_meet; prev_per_b = e_per; prev_attr_b = e_attr;
   endtask

   task automatic test_reset_mid_search();
      int bc, rc, sc;
      logic tf;
      bit fin, found;
      mode_a = F_ROTL; init_a = 3'b001;
      @(negedge clk); start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      found = 0;
      for (int c = 0; c < 50; c++) begin
         if (busy_a && start_s1_a && !start_s0_a) begin found = 1; break; end
         @(negedge clk);
      end
      tests++;
      if (!found) begin fails++; $display("[TB] FAIL midrst_period phase not observed within 50 cycles"); end
      rst_a = 1'b1;
      @(negedge clk);
      tests++;
      if ({reset_nos_a, start_s0_a, start_s1_a, busy_a, done_a, timeout_a,
           init_state_a, attr_a, meet_a, period_a} !== '0) begin
         fails++;
         $display("[TB] FAIL midrst_outputs busy=%b done=%b s1=%b meet=%0d attr=%b, all 0 required",
                  busy_a, done_a, start_s1_a, meet_a, attr_a);
      end
      rst_a = 1'b0;
      run_search(0, -1, bc, rc, sc, tf, fin);
      tests++;
      if (!fin || meet_a !== 16'd6 || period_a !== 16'd3 || attr_a !== 3'b001 || timeout_a !== 1'b0) begin
         fails++;
         $display("[TB] FAIL midrst_rerun fin=%b meet=%0d period=%0d attr=%b to=%b, required 1 6 3 001 0",
                  fin, meet_a, period_a, attr_a, timeout_a);
      end
   endtask

   task automatic test_back_to_back();
      int bc, rc, sc;
      logic tf;
      bit fin;
      mode_a = F_ROTL; init_a = 3'b001;
      run_search(0, 3, bc, rc, sc, tf, fin);
      tests++;
      if (!fin || meet_a !== 16'd6 || period_a !== 16'd3 || attr_a !== 3'b001 || init_state_a !== 3'b001) begin
         fails++;
         $display("[TB] FAIL ignore_start fin=%b meet=%0d period=%0d attr=%b init=%b, required 1 6 3 001 001",
                  fin, meet_a, period_a, attr_a, init_state_a);
      end
      tests++;
      if (rc !== 1) begin
         fails++;
         $display("[TB] FAIL ignore_start reset_nos high for %0d cycles, required 1", rc);
      end
      mode_b = F_IDENT; init_b = 3'b101;
      run_search(1, -1, bc, rc, sc, tf, fin);
      tests++;
      if (tf !== 1'b0) begin
         fails++;
         $display("[TB] FAIL restart_clears_timeout timeout after start=%b, required 0", tf);
      end
      tests++;
      if (!fin || meet_b !== 16'd2 || period_b !== 16'd1 || attr_b !== 3'b101 || timeout_b !== 1'b0) begin
         fails++;
         $display("[TB] FAIL restart_result fin=%b meet=%0d period=%0d attr=%b to=%b, required 1 2 1 101 0",
                  fin, meet_b, period_b, attr_b, timeout_b);
      end
      prev_meet_b = 2; prev_per_b = 1; prev_attr_b = 3'b101;
   endtask

   task automatic test_random();
      int bc, rc, sc, e_meet, e_per, e_busy, e_steps;
      logic [N-1:0] e_attr, x0;
      logic [23:0] tb;
      logic tf, e_to;
      bit fin;
      for (int i = 0; i < 16; i++) begin
         tb = 24'($urandom()); x0 = 3'($urandom_range(0, 7));
         mode_a = F_TABLE; tbl_a = tb; init_a = x0;
         model(F_TABLE, tb, x0, MAX_A, 0, 0, '0, e_meet, e_per, e_attr, e_to, e_busy, e_steps);
         run_search(0, -1, bc, rc, sc, tf, fin);
         tests++;
         if (!fin || meet_a !== CW'(e_meet) || period_a !== CW'(e_per) || attr_a !== e_attr ||
             timeout_a !== e_to || bc !== e_busy || sc !== e_steps) begin
            fails++;
            $display("[TB] FAIL rand_a[%0d] got fin=%b meet=%0d per=%0d attr=%b to=%b busy=%0d steps=%0d, required 1 %0d %0d %b %b %0d %0d",
                     i, fin, meet_a, period_a, attr_a, timeout_a, bc, sc, e_meet, e_per, e_attr, e_to, e_busy, e_steps);
         end
      end
      for (int i = 0; i < 16; i++) begin
         tb = 24'($urandom()); x0 = 3'($urandom_range(0, 7));
         mode_b = F_TABLE; tbl_b = tb; init_b = x0;
         model(F_TABLE, tb, x0, MAX_B, prev_meet_b, prev_per_b, prev_attr_b,
               e_meet, e_per, e_attr, e_to, e_busy, e_steps);
         run_search(1, -1, bc, rc, sc, tf, fin);
         tests++;
         if (!fin || meet_b !== CW'(e_meet) || period_b !== CW'(e_per) || attr_b !== e_attr ||
             timeout_b !== e_to || bc !== e_busy || sc !== e_steps) begin
            fails++;
            $display("[TB] FAIL rand_b[%0d] got fin=%b meet=%0d per=%0d attr=%b to=%b busy=%0d steps=%0d, required 1 %0d %0d %b %b %0d %0d",
                     i, fin, meet_b, period_b, attr_b, timeout_b, bc, sc, e_meet, e_per, e_attr, e_to, e_busy, e_steps);
         end
         prev_meet_b = e_meet; prev_per_b = e_per; prev_attr_b = e_attr;
      end
   endtask

   // Scenario sequence; each task drives its own stimulus and checks.
   initial begin
      test_reset();
      test_identity();
      test_rotl();
      test_const();
      test_timeout();
      test_reset_mid_search();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
